// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : Program loader and instruction fetch front end. Bytes are
//               streamed into a 256 x 8 program memory while in LOAD. The
//               memory is then served combinationally at the CPU's pc while
//               in RUN. Execution halts once pc runs past the loaded length.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
  parameter logic [7:0] NOP_WORD = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_start,
  input  logic       load_valid,
  input  logic [7:0] load_data,
  input  logic       load_last,
  output logic       load_ready,
  input  logic       run,
  input  logic [7:0] pc,
  output logic [7:0] instruction,
  output logic       cpu_reset,
  output logic [1:0] state,
  output logic [8:0] prog_len,
  output logic       full
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_LOAD = 2'b01,
    S_RUN  = 2'b10,
    S_HALT = 2'b11
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_addr;
  logic [8:0] r_prog_len;
  logic       r_full;
  logic [7:0] r_mem [256];

  logic       w_accept;
  logic       w_at_end;
  logic       w_enter_load;
  logic       w_past_end;

  assign w_accept     = (r_state == S_LOAD) && load_valid;
  assign w_at_end     = (r_addr == 8'hFF);
  assign w_enter_load = (w_next == S_LOAD) && (r_state != S_LOAD);
  // Length check is 9 bits wide so prog_len = 256 can never be reached by pc.
  assign w_past_end   = !r_full && ({1'b0, pc} >= r_prog_len);

  // State register; reset abandons any load in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode and state-derived outputs; load_start always wins.
  always_comb begin
    w_next      = r_state;
    load_ready  = 1'b0;
    cpu_reset   = 1'b1;
    instruction = NOP_WORD;
    case (r_state)
      S_IDLE: begin
        if (load_start) begin
          w_next = S_LOAD;
        end else if (run) begin
          w_next = S_RUN;
        end
      end
      S_LOAD: begin
        load_ready = 1'b1;
        if (w_accept && (load_last || w_at_end)) begin
          w_next = S_IDLE;
        end
      end
      S_RUN: begin
        cpu_reset   = 1'b0;
        instruction = r_mem[pc];
        if (load_start) begin
          w_next = S_LOAD;
        end else if (!run) begin
          w_next = S_IDLE;
        end else if (w_past_end) begin
          w_next = S_HALT;
        end
      end
      S_HALT: begin
        if (load_start) begin
          w_next = S_LOAD;
        end else if (!run) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Load bookkeeping: cleared on entry to LOAD, advanced per accepted byte.
  // The 8-bit address wraps to 0 naturally after the 256th byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr     <= 8'd0;
      r_prog_len <= 9'd0;
      r_full     <= 1'b0;
    end else if (w_enter_load) begin
      r_addr     <= 8'd0;
      r_prog_len <= 9'd0;
      r_full     <= 1'b0;
    end else if (w_accept) begin
      r_addr     <= r_addr + 8'd1;
      r_prog_len <= r_prog_len + 9'd1;
      if (w_at_end) begin
        r_full <= 1'b1;
      end
    end
  end

  // Program memory write port; deliberately not reset so contents survive.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mem[r_addr] <= load_data;
    end
  end

  assign state    = r_state;
  assign prog_len = r_prog_len;
  assign full     = r_full;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_unit
// Description : Directed self-checking bench for instr_fetch_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

  localparam logic [7:0] NOP = 8'hEA;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load_start = 1'b0;
  logic       load_valid = 1'b0;
  logic [7:0] load_data = 8'h00;
  logic       load_last = 1'b0;
  logic       load_ready;
  logic       run = 1'b0;
  logic [7:0] pc = 8'h00;
  logic [7:0] instruction;
  logic       cpu_reset;
  logic [1:0] state;
  logic [8:0] prog_len;
  logic       full;

  int n_cmp = 0;
  int n_err = 0;

  instr_fetch_unit #(.NOP_WORD(NOP)) dut (
    .clk(clk), .reset(reset), .load_start(load_start), .load_valid(load_valid),
    .load_data(load_data), .load_last(load_last), .load_ready(load_ready),
    .run(run), .pc(pc), .instruction(instruction), .cpu_reset(cpu_reset),
    .state(state), .prog_len(prog_len), .full(full)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++; if (state !== 2'b00) begin n_err++; $display("FAIL rst_state: got %b want %b", state, 2'b00); end
    n_cmp++; if (prog_len !== 9'd0) begin n_err++; $display("FAIL rst_prog_len: got %0d want 0", prog_len); end
    n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL rst_full: got %b want 0", full); end
    n_cmp++; if (load_ready !== 1'b0) begin n_err++; $display("FAIL rst_load_ready: got %b want 0", load_ready); end
    n_cmp++; if (cpu_reset !== 1'b1) begin n_err++; $display("FAIL rst_cpu_reset: got %b want 1", cpu_reset); end
    n_cmp++; if (instruction !== NOP) begin n_err++; $display("FAIL rst_instr: got %h want %h", instruction, NOP); end
    #1 reset = 1'b0;
    tick();
  endtask

  task automatic test_load3();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    n_cmp++; if (state !== 2'b01) begin n_err++; $display("FAIL l3_enter: got %b want 01", state); end
    n_cmp++; if (load_ready !== 1'b1) begin n_err++; $display("FAIL l3_ready: got %b want 1", load_ready); end
    load_valid = 1'b1; load_data = 8'hA1;
    tick();
    n_cmp++; if (prog_len !== 9'd1) begin n_err++; $display("FAIL l3_len1: got %0d want 1", prog_len); end
    load_data = 8'hB2;
    tick();
    load_data = 8'hC3; load_last = 1'b1;
    tick();
    load_valid = 1'b0; load_last = 1'b0;
    n_cmp++; if (state !== 2'b00) begin n_err++; $display("FAIL l3_done_state: got %b want 00", state); end
    n_cmp++; if (prog_len !== 9'd3) begin n_err++; $display("FAIL l3_len: got %0d want 3", prog_len); end
    n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL l3_full: got %b want 0", full); end
    n_cmp++; if (load_ready !== 1'b0) begin n_err++; $display("FAIL l3_ready_off: got %b want 0", load_ready); end
  endtask

  task automatic test_run3();
    logic [7:0] exp [3];
    exp[0] = 8'hA1; exp[1] = 8'hB2; exp[2] = 8'hC3;
    run = 1'b1; pc = 8'd0;
    tick();
    n_cmp++; if (state !== 2'b10) begin n_err++; $display("FAIL r3_state: got %b want 10", state); end
    n_cmp++; if (cpu_reset !== 1'b0) begin n_err++; $display("FAIL r3_cpu_reset: got %b want 0", cpu_reset); end
    for (int i = 0; i < 3; i++) begin
      pc = i[7:0];
      #1;
      n_cmp++; if (instruction !== exp[i]) begin n_err++; $display("FAIL r3_instr_pc%0d: got %h want %h", i, instruction, exp[i]); end
      tick();
      n_cmp++; if (state !== 2'b10) begin n_err++; $display("FAIL r3_no_halt_pc%0d: got %b want 10", i, state); end
    end
    pc = 8'd3;
    tick();
    n_cmp++; if (state !== 2'b11) begin n_err++; $display("FAIL r3_halt: got %b want 11", state); end
    n_cmp++; if (instruction !== NOP) begin n_err++; $display("FAIL r3_halt_instr: got %h want %h", instruction, NOP); end
    n_cmp++; if (cpu_reset !== 1'b1) begin n_err++; $display("FAIL r3_halt_cpu_reset: got %b want 1", cpu_reset); end
    pc = 8'd0;
    tick();
    n_cmp++; if (state !== 2'b11) begin n_err++; $display("FAIL r3_halt_stays: got %b want 11", state); end
    run = 1'b0;
    tick();
    n_cmp++; if (state !== 2'b00) begin n_err++; $display("FAIL r3_to_idle: got %b want 00", state); end
  endtask

  task automatic test_ignore_valid();
    load_valid = 1'b1; load_data = 8'h5A;
    #1;
    n_cmp++; if (load_ready !== 1'b0) begin n_err++; $display("FAIL ig_idle_ready: got %b want 0", load_ready); end
    tick();
    load_valid = 1'b0;
    run = 1'b1; pc = 8'd0;
    tick();
    load_valid = 1'b1;
    #1;
    n_cmp++; if (load_ready !== 1'b0) begin n_err++; $display("FAIL ig_run_ready: got %b want 0", load_ready); end
    tick();
    load_valid = 1'b0;
    n_cmp++; if (instruction !== 8'hA1) begin n_err++; $display("FAIL ig_mem0: got %h want A1", instruction); end
    pc = 8'd3;
    #1;
    n_cmp++; if (instruction === 8'h5A) begin n_err++; $display("FAIL ig_mem3: got %h want not 5A", instruction); end
    n_cmp++; if (prog_len !== 9'd3) begin n_err++; $display("FAIL ig_len: got %0d want 3", prog_len); end
    run = 1'b0; pc = 8'd0;
    tick();
  endtask

  task automatic test_priority();
    load_start = 1'b1; run = 1'b1;
    tick();
    load_start = 1'b0; run = 1'b0;
    n_cmp++; if (state !== 2'b01) begin n_err++; $display("FAIL pr_idle_load_wins: got %b want 01", state); end
    load_valid = 1'b1; load_data = 8'h11;
    tick();
    load_data = 8'h22; load_last = 1'b1;
    tick();
    load_valid = 1'b0; load_last = 1'b0;
    n_cmp++; if (prog_len !== 9'd2) begin n_err++; $display("FAIL pr_len: got %0d want 2", prog_len); end
    run = 1'b1; pc = 8'd1;
    tick();
    n_cmp++; if (instruction !== 8'h22) begin n_err++; $display("FAIL pr_run_instr: got %h want 22", instruction); end
    load_start = 1'b1;
    tick();
    load_start = 1'b0; run = 1'b0;
    n_cmp++; if (state !== 2'b01) begin n_err++; $display("FAIL pr_abort_state: got %b want 01", state); end
    n_cmp++; if (cpu_reset !== 1'b1) begin n_err++; $display("FAIL pr_abort_cpu_reset: got %b want 1", cpu_reset); end
    n_cmp++; if (prog_len !== 9'd0) begin n_err++; $display("FAIL pr_abort_len: got %0d want 0", prog_len); end
    n_cmp++; if (instruction !== NOP) begin n_err++; $display("FAIL pr_abort_instr: got %h want %h", instruction, NOP); end
  endtask

  // Still in LOAD from the aborted run.
  task automatic test_reset_mid_load();
    load_valid = 1'b1; load_data = 8'h33;
    tick();
    load_data = 8'h44;
    tick();
    n_cmp++; if (prog_len !== 9'd2) begin n_err++; $display("FAIL rm_len2: got %0d want 2", prog_len); end
    load_data = 8'h55;
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (state !== 2'b00) begin n_err++; $display("FAIL rm_async_state: got %b want 00", state); end
    n_cmp++; if (prog_len !== 9'd0) begin n_err++; $display("FAIL rm_len0: got %0d want 0", prog_len); end
    #1 reset = 1'b0; load_valid = 1'b0;
    run = 1'b1; pc = 8'd0;
    tick();
    n_cmp++; if (state !== 2'b10) begin n_err++; $display("FAIL rm_run: got %b want 10", state); end
    n_cmp++; if (instruction !== 8'h33) begin n_err++; $display("FAIL rm_mem0: got %h want 33", instruction); end
    pc = 8'd1;
    #1;
    n_cmp++; if (instruction !== 8'h44) begin n_err++; $display("FAIL rm_mem1: got %h want 44", instruction); end
    tick();
    n_cmp++; if (state !== 2'b11) begin n_err++; $display("FAIL rm_empty_halt: got %b want 11", state); end
    run = 1'b0;
    tick();
  endtask

  task automatic test_full();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 256; i++) begin
      load_valid = 1'b1; load_data = i[7:0];
      tick();
      if (i == 254) begin
        n_cmp++; if (prog_len !== 9'd255 || state !== 2'b01) begin n_err++; $display("FAIL fu_len255: got %0d/%b want 255/01", prog_len, state); end
      end
    end
    load_valid = 1'b0;
    n_cmp++; if (state !== 2'b00) begin n_err++; $display("FAIL fu_state: got %b want 00", state); end
    n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL fu_full: got %b want 1", full); end
    n_cmp++; if (prog_len !== 9'd256) begin n_err++; $display("FAIL fu_len: got %0d want 256", prog_len); end
    run = 1'b1; pc = 8'd255;
    tick();
    n_cmp++; if (instruction !== 8'hFF) begin n_err++; $display("FAIL fu_instr255: got %h want FF", instruction); end
    pc = 8'd128;
    #1;
    n_cmp++; if (instruction !== 8'h80) begin n_err++; $display("FAIL fu_instr128: got %h want 80", instruction); end
    pc = 8'd255;
    tick();
    tick();
    n_cmp++; if (state !== 2'b10) begin n_err++; $display("FAIL fu_no_halt: got %b want 10", state); end
    run = 1'b0;
    tick();
    n_cmp++; if (state !== 2'b00) begin n_err++; $display("FAIL fu_idle: got %b want 00", state); end
  endtask

  initial begin
    test_reset();
    test_load3();
    test_run3();
    test_ignore_valid();
    test_priority();
    test_reset_mid_load();
    test_full();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
